// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory access FSM and MEM/WB register.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   *_e               execute-stage results and control bits
//   stall_m           holds EX/MEM and the upstream stages during an access
//   dmem_*            req/gnt/rvalid data-memory bus
//   *_w               write-back bundle plus one-cycle misalign/timeout flags
module mem_stage #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_e,
    input  logic [31:0] write_data_e,
    input  logic [4:0]  write_reg_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic        mem_write_e,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] result_w,
    output logic [4:0]  write_reg_w,
    output logic        reg_write_w,
    output logic        misalign_w,
    output logic        timeout_w
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
    } ex_mem_t;

    state_t      state;
    state_t      state_nx;
    ex_mem_t     m;
    logic [31:0] load_latch;
    logic [15:0] cnt;
    logic        to_flag;

    logic mem_op;
    logic aligned;
    logic mem_op_e;
    logic aligned_e;
    logic ld_rdata;
    logic ld_err;
    logic cnt_inc;
    logic cnt_clr;

    assign mem_op    = m.mem_to_reg | m.mem_write;
    assign aligned   = m.alu_out[1:0] == 2'b00;
    assign mem_op_e  = mem_to_reg_e | mem_write_e;
    assign aligned_e = alu_out_e[1:0] == 2'b00;
    assign stall_m   = (state == REQ) | (state == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ld_rdata   = 1'b0;
        ld_err     = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        unique case (state)
            IDLE, DONE: begin
                // DONE is not stalled, so a new instruction is captured here
                if (mem_op_e) begin
                    state_nx = aligned_e ? REQ : DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = m.mem_write;
                dmem_addr  = {m.alu_out[31:2], 2'b00};
                dmem_wdata = m.write_data;
                if (dmem_gnt) begin
                    if (m.mem_write) begin
                        state_nx = DONE;
                    end else if (dmem_rvalid) begin
                        ld_rdata = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cnt_clr  = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    ld_rdata = 1'b1;
                    state_nx = DONE;
                end else if (cnt == TO_LAST) begin
                    ld_err   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '0;
        end else if (!stall_m) begin
            m <= '{alu_out_e, write_data_e, write_reg_e,
                   reg_write_e, mem_to_reg_e, mem_write_e};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_latch <= '0;
            cnt        <= '0;
            to_flag    <= 1'b0;
        end else begin
            if (ld_rdata) begin
                load_latch <= dmem_rdata;
            end else if (ld_err) begin
                load_latch <= ERR_DATA;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 16'd1;
            end
            // W samples the old flag on the same edge that clears it
            if (ld_err) begin
                to_flag <= 1'b1;
            end else if (!stall_m) begin
                to_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_w    <= '0;
            write_reg_w <= '0;
            reg_write_w <= 1'b0;
            misalign_w  <= 1'b0;
            timeout_w   <= 1'b0;
        end else if (!stall_m) begin
            result_w    <= m.mem_to_reg ? load_latch : m.alu_out;
            write_reg_w <= m.write_reg;
            reg_write_w <= m.reg_write & ~(mem_op & ~aligned);
            misalign_w  <= mem_op & ~aligned;
            timeout_w   <= to_flag;
        end else begin
            reg_write_w <= 1'b0;
            misalign_w  <= 1'b0;
            timeout_w   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed results.
// Inputs change on the falling edge; outputs are checked #1 after it.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out_e;
    logic [31:0] write_data_e;
    logic [4:0]  write_reg_e;
    logic        reg_write_e;
    logic        mem_to_reg_e;
    logic        mem_write_e;
    logic        stall_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] result_w;
    logic [4:0]  write_reg_w;
    logic        reg_write_w;
    logic        misalign_w;
    logic        timeout_w;

    int n_chk = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_out_e    (alu_out_e),
        .write_data_e (write_data_e),
        .write_reg_e  (write_reg_e),
        .reg_write_e  (reg_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_write_e  (mem_write_e),
        .stall_m      (stall_m),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .result_w     (result_w),
        .write_reg_w  (write_reg_w),
        .reg_write_w  (reg_write_w),
        .misalign_w   (misalign_w),
        .timeout_w    (timeout_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic set_e(input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] wr, input logic rw,
                         input logic m2r, input logic mw);
        alu_out_e    = a;
        write_data_e = wd;
        write_reg_e  = wr;
        reg_write_e  = rw;
        mem_to_reg_e = m2r;
        mem_write_e  = mw;
    endtask

    task automatic nop();
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int waits;
        rst         = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        nop();
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_result", result_w, 32'h0);
        check("rst_rw", 32'(reg_write_w), 32'd0);
        check("rst_flags", {30'd0, misalign_w, timeout_w}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU op
        set_e(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        nop();
        #1;
        check("alu_stall", 32'(stall_m), 32'd0);
        cyc();
        check("alu_result", result_w, 32'h1234);
        check("alu_wreg", 32'(write_reg_w), 32'd5);
        check("alu_rw", 32'(reg_write_w), 32'd1);
        cyc();
        check("alu_rw_once", 32'(reg_write_w), 32'd0);

        // zero-wait load
        set_e(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        cyc();
        nop();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_0001;
        #1;
        check("ld0_req", 32'(dmem_req), 32'd1);
        check("ld0_addr", dmem_addr, 32'h100);
        check("ld0_we", 32'(dmem_we), 32'd0);
        check("ld0_stall", 32'(stall_m), 32'd1);
        cyc();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        check("ld0_stall_end", 32'(stall_m), 32'd0);
        check("ld0_bubble", 32'(reg_write_w), 32'd0);
        cyc();
        check("ld0_result", result_w, 32'hCAFE_0001);
        check("ld0_rw", 32'(reg_write_w), 32'd1);
        check("ld0_wreg", 32'(write_reg_w), 32'd7);

        // store granted on the third REQ cycle
        set_e(32'h204, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        nop();
        for (int i = 0; i < 3; i++) begin
            dmem_gnt = (i == 2);
            #1;
            check("st_req", 32'(dmem_req), 32'd1);
            check("st_we", 32'(dmem_we), 32'd1);
            check("st_addr", dmem_addr, 32'h204);
            check("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
            check("st_stall", 32'(stall_m), 32'd1);
            if (i == 1) check("st_bubble", 32'(reg_write_w), 32'd0);
            cyc();
        end
        dmem_gnt = 1'b0;
        #1;
        check("st_stall_end", 32'(stall_m), 32'd0);
        check("st_req_end", 32'(dmem_req), 32'd0);
        cyc();
        check("st_rw", 32'(reg_write_w), 32'd0);
        check("st_result", result_w, 32'h204);

        // misaligned load
        set_e(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc();
        nop();
        #1;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(stall_m), 32'd0);
        cyc();
        check("mis_flag", 32'(misalign_w), 32'd1);
        check("mis_rw", 32'(reg_write_w), 32'd0);
        check("mis_wreg", 32'(write_reg_w), 32'd9);
        cyc();
        check("mis_flag_once", 32'(misalign_w), 32'd0);

        // load timeout
        set_e(32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        cyc();
        nop();
        dmem_gnt = 1'b1;
        #1;
        check("to_req", 32'(dmem_req), 32'd1);
        cyc();
        dmem_gnt = 1'b0;
        waits = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!stall_m) break;
            if (k == 0) check("to_wait_req", 32'(dmem_req), 32'd0);
            waits++;
            cyc();
        end
        check("to_wait_len", 32'(waits), 32'd4);
        cyc();
        check("to_result", result_w, 32'hDEAD_BEEF);
        check("to_flag", 32'(timeout_w), 32'd1);
        check("to_rw", 32'(reg_write_w), 32'd1);
        check("to_wreg", 32'(write_reg_w), 32'd3);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        #1;
        check("stray_stall", 32'(stall_m), 32'd0);
        check("stray_req", 32'(dmem_req), 32'd0);
        cyc();
        dmem_rvalid = 1'b0;
        check("stray_flag", 32'(timeout_w), 32'd0);
        check("stray_result", result_w, 32'h0);

        // reset while a load waits
        set_e(32'h55, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
        cyc();
        set_e(32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        cyc();
        nop();
        dmem_gnt = 1'b1;
        #1;
        check("rw_pre_result", result_w, 32'h55);
        cyc();
        dmem_gnt = 1'b0;
        #1;
        check("rst_mid_stall", 32'(stall_m), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_stall0", 32'(stall_m), 32'd0);
        check("rst_mid_result", result_w, 32'h0);
        check("rst_mid_wreg", 32'(write_reg_w), 32'd0);
        check("rst_mid_rw", 32'(reg_write_w), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        set_e(32'h77, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
        cyc();
        nop();
        #1;
        check("post_stall", 32'(stall_m), 32'd0);
        cyc();
        check("post_result", result_w, 32'h77);
        check("post_wreg", 32'(write_reg_w), 32'd8);
        check("post_rw", 32'(reg_write_w), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
